// File: rtl/ram_access_ctrl.sv
// Window-RAM arbiter: round-robin between 5x5 window reads and single-word writes, one RAM transaction at a time.
// Latency: ack 1 cycle after the request-sampling edge, done 2 cycles after ack with an ideal RAM, 4 cycles per transaction.
// Backpressure: requesters hold req until ack; requests seen outside IDLE simply wait. Optional timeout: RAM_ACC_TIMEOUT_EN.
module ram_access_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int KSIZE          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rd_req_i,
    input  logic [ADDR_W-1:0]               rd_addr_i,
    input  logic [ADDR_W-1:0]               rd_offset_i,
    output logic                            rd_ack_o,
    output logic                            rd_done_o,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   rd_window_o,
    input  logic                            wr_req_i,
    input  logic [ADDR_W-1:0]               wr_addr_i,
    input  logic [DATA_W-1:0]               wr_data_i,
    output logic                            wr_ack_o,
    output logic                            wr_done_o,
    output logic                            ram_en_o,
    output logic                            ram_write_o,
    output logic [ADDR_W-1:0]               ram_addr_o,
    output logic [ADDR_W-1:0]               ram_offset_o,
    output logic [DATA_W-1:0]               ram_data_o,
    input  logic [KSIZE*KSIZE*DATA_W-1:0]   ram_window_i,
    input  logic                            ram_finish_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0] state;
    logic       last_grant_wr;   // 1: the previous grant went to the writer
    logic       owner_wr;        // side that owns the transaction in flight
    logic       grant_rd;
    logic       grant_wr;
    logic       timeout_hit;

    // Round-robin pick: on contention the side that did not win last time goes first
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rd_req_i && wr_req_i) begin
            if (last_grant_wr) begin
                grant_rd = 1'b1;
            end else begin
                grant_wr = 1'b1;
            end
        end else if (rd_req_i) begin
            grant_rd = 1'b1;
        end else if (wr_req_i) begin
            grant_wr = 1'b1;
        end
    end

`ifdef RAM_ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // A real finish in the same cycle as the limit wins: the data is good, so no error
    assign timeout_hit = (state == S_WAIT) && !ram_finish_i &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter, cleared in ISSUE so every transaction starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !ram_finish_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Transaction sequencer: grant, issue, wait for finish, then one enable-low cycle to re-arm the RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            last_grant_wr <= 1'b1;
            owner_wr      <= 1'b0;
            rd_ack_o      <= 1'b0;
            rd_done_o     <= 1'b0;
            rd_window_o   <= '0;
            wr_ack_o      <= 1'b0;
            wr_done_o     <= 1'b0;
            ram_en_o      <= 1'b0;
            ram_write_o   <= 1'b0;
            ram_addr_o    <= '0;
            ram_offset_o  <= '0;
            ram_data_o    <= '0;
            busy_o        <= 1'b0;
        end else begin
            rd_ack_o  <= 1'b0;
            wr_ack_o  <= 1'b0;
            rd_done_o <= 1'b0;
            wr_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_rd || grant_wr) begin
                        state         <= S_ISSUE;
                        busy_o        <= 1'b1;
                        ram_en_o      <= 1'b1;
                        ram_write_o   <= grant_wr;
                        owner_wr      <= grant_wr;
                        last_grant_wr <= grant_wr;
                        if (grant_wr) begin
                            ram_addr_o <= wr_addr_i;
                            ram_data_o <= wr_data_i;
                            wr_ack_o   <= 1'b1;
                        end else begin
                            ram_addr_o   <= rd_addr_i;
                            ram_offset_o <= rd_offset_i;
                            rd_ack_o     <= 1'b1;
                        end
                    end
                end
                // The finish flag may still be set from the previous transaction; the enable
                // edge the RAM sees this cycle clears it, so it is not looked at here.
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_finish_i || timeout_hit) begin
                        state       <= S_RELEASE;
                        ram_en_o    <= 1'b0;
                        ram_write_o <= 1'b0;
                        if (owner_wr) begin
                            wr_done_o <= 1'b1;
                        end else begin
                            rd_done_o <= 1'b1;
                            if (ram_finish_i) begin
                                rd_window_o <= ram_window_i;
                            end
                        end
                    end
                end
                S_RELEASE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_o   <= 1'b0;
                    ram_en_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed scenarios plus randomized reads/writes against a behavioural RAM.
// Expected windows come from a shadow memory updated by the bench's own write stream.
// Timing expectations: ack 1 cycle after request, done 2+latency cycles after ack, enable low between transactions.
module tb_ram_access_ctrl;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int KSIZE          = 5;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int WIN_W          = KSIZE * KSIZE * DATA_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rd_req = 1'b0;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic [ADDR_W-1:0]  rd_off = '0;
    logic               rd_ack_o;
    logic               rd_done_o;
    logic [WIN_W-1:0]   rd_window_o;
    logic               wr_req = 1'b0;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic [DATA_W-1:0]  wr_data = '0;
    logic               wr_ack_o;
    logic               wr_done_o;
    logic               ram_en_o;
    logic               ram_write_o;
    logic [ADDR_W-1:0]  ram_addr_o;
    logic [ADDR_W-1:0]  ram_offset_o;
    logic [DATA_W-1:0]  ram_data_o;
    logic [WIN_W-1:0]   ram_window = '0;
    logic               ram_finish = 1'b0;
    logic               busy_o;
    logic               err_o;

    int errors = 0;
    int checks = 0;

    ram_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .KSIZE(KSIZE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_offset_i(rd_off),
        .rd_ack_o(rd_ack_o), .rd_done_o(rd_done_o), .rd_window_o(rd_window_o),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ack_o(wr_ack_o), .wr_done_o(wr_done_o),
        .ram_en_o(ram_en_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
        .ram_offset_o(ram_offset_o), .ram_data_o(ram_data_o),
        .ram_window_i(ram_window), .ram_finish_i(ram_finish),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [DATA_W-1:0] ram_mem [0:65535];
    logic [DATA_W-1:0] ref_mem [0:65535];
    logic              mem_ready = 1'b0;
    logic              en_prev = 1'b0;
    logic              pending = 1'b0;
    int                lat_cnt = 0;
    int                ram_lat = 0;
    bit                ram_hang = 1'b0;
    logic [ADDR_W-1:0] op_addr, op_off;
    logic [DATA_W-1:0] op_data;
    logic              op_wr;

    function automatic logic [DATA_W-1:0] seed_val(input int i);
        return DATA_W'((i * 40503) ^ 32'h0000A5C3);
    endfunction

    function automatic logic [WIN_W-1:0] ram_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] off);
        logic [WIN_W-1:0]  w;
        logic [ADDR_W-1:0] idx;
        w = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                idx = a + ADDR_W'(off * r) + ADDR_W'(c);
                w[(r*KSIZE+c)*DATA_W +: DATA_W] = ram_mem[idx];
            end
        end
        return w;
    endfunction

    // Reference window: element (r,c) is mem[addr + offset*r + c], row 0 col 0 in the LSBs
    function automatic logic [WIN_W-1:0] ref_win(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] off);
        logic [WIN_W-1:0]  w;
        logic [ADDR_W-1:0] idx;
        w = '0;
        for (int k = 0; k < KSIZE * KSIZE; k++) begin
            idx = a + ADDR_W'(off * (k / KSIZE)) + ADDR_W'(k % KSIZE);
            w[k*DATA_W +: DATA_W] = ref_mem[idx];
        end
        return w;
    endfunction

    // RAM: enable rising edge clears finish, then the access completes after ram_lat cycles
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) ram_mem[i] = seed_val(i);
            mem_ready = 1'b1;
        end
        en_prev <= ram_en_o;
        if (ram_en_o && !en_prev) begin
            ram_finish <= 1'b0;
            op_addr = ram_addr_o;
            op_off  = ram_offset_o;
            op_data = ram_data_o;
            op_wr   = ram_write_o;
            if (ram_hang) begin
                pending <= 1'b0;
            end else if (ram_lat == 0) begin
                if (op_wr) ram_mem[op_addr] = op_data;
                else ram_window <= ram_read(op_addr, op_off);
                ram_finish <= 1'b1;
                pending    <= 1'b0;
            end else begin
                pending <= 1'b1;
                lat_cnt <= ram_lat;
            end
        end else if (pending) begin
            if (lat_cnt <= 1) begin
                if (op_wr) ram_mem[op_addr] = op_data;
                else ram_window <= ram_read(op_addr, op_off);
                ram_finish <= 1'b1;
                pending    <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    logic [WIN_W-1:0] last_win = '0;

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_win = '0;
    endtask

    // One complete transaction; arg is the row offset for reads, the data word for writes
    task automatic do_txn(input bit is_wr, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] arg, input int lat);
        logic [WIN_W-1:0] exp_win;
        int waited, exp_d, lines_ok;
        exp_win = '0;
        ram_lat = lat;
        @(negedge clk);
        if (is_wr) begin
            wr_req = 1'b1; wr_addr = a; wr_data = arg;
        end else begin
            rd_req = 1'b1; rd_addr = a; rd_off = arg;
        end
        for (waited = 1; waited <= 10; waited++) begin
            @(negedge clk);
            if (is_wr ? wr_ack_o : rd_ack_o) break;
        end
        chk("ack_latency", waited, 1);
        chk("ack_other_side", is_wr ? rd_ack_o : wr_ack_o, 0);
        chk("ack_ram_en", ram_en_o, 1);
        chk("ack_ram_write", ram_write_o, is_wr);
        chk("ack_ram_addr", ram_addr_o, a);
        chk("ack_ram_arg", is_wr ? ram_data_o : ram_offset_o, arg);
        chk("ack_busy", busy_o, 1);
        // requester lets go and is free to change its arguments
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = ADDR_W'($urandom); rd_off = ADDR_W'($urandom);
        wr_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom);
        if (is_wr) ref_mem[a] = arg;
        else exp_win = ref_win(a, arg);
        exp_d = ram_hang ? TIMEOUT_CYCLES + 1 : lat + 2;
        lines_ok = 1;
        for (waited = 1; waited <= TIMEOUT_CYCLES + 20; waited++) begin
            @(negedge clk);
            if (is_wr ? wr_done_o : rd_done_o) break;
            if (!ram_en_o || ram_addr_o !== a || ram_write_o !== is_wr) lines_ok = 0;
        end
        chk("done_latency", waited, exp_d);
        chk("ram_lines_stable", lines_ok, 1);
        chk("done_other_side", is_wr ? rd_done_o : wr_done_o, 0);
        chk("done_ram_en_low", ram_en_o, 0);
        chk("done_err", err_o, ram_hang);
        if (!is_wr && !ram_hang) last_win = exp_win;
        chk("window", rd_window_o, last_win);
        @(negedge clk);
        chk("release_ram_en_low", ram_en_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_ram_write", ram_write_o, 0);
        chk("done_one_cycle", is_wr ? wr_done_o : rd_done_o, 0);
    endtask

    // ---------------- stimulus ----------------
    int               ev_cyc [8];
    bit               ev_wr [8];
    int               nev, nrd_done, nwr_done;
    bit               op_is_wr;
    logic [ADDR_W-1:0] r_addr, r_arg;

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = seed_val(i);
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ram_en", ram_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_acks", {rd_ack_o, wr_ack_o}, 0);
        chk("rst_dones", {rd_done_o, wr_done_o}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_window", rd_window_o, 0);
        chk("rst_ram_lines", {ram_write_o, ram_addr_o, ram_offset_o, ram_data_o}, 0);
        rst_n = 1'b1;

        // single read, then write followed by a read of the written word
        do_txn(1'b0, 16'd100, 16'd20, 0);
        do_txn(1'b1, 16'd7, 16'h1234, 0);
        do_txn(1'b0, 16'd7, 16'd3, 0);
        r_arg = rd_window_o[DATA_W-1:0];
        chk("wr_then_rd_elem00", r_arg, 16'h1234);

        // back-to-back reads with a slow RAM: a stale finish must not end the second one early
        do_txn(1'b0, 16'd0, 16'd1, 1);
        do_txn(1'b0, 16'd5, 16'd1, 2);

        // contention from reset: RD first, then strict alternation every 4 cycles
        do_reset();
        ram_lat = 0;
        rd_addr = 16'd1000; rd_off = 16'd30; wr_addr = 16'd7000; wr_data = DATA_W'($urandom);
        rd_req = 1'b1; wr_req = 1'b1;
        nev = 0; nrd_done = 0; nwr_done = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if ((rd_ack_o || wr_ack_o) && nev < 8) begin
                ev_cyc[nev] = cyc;
                ev_wr[nev]  = wr_ack_o && !rd_ack_o;
                nev++;
            end
            if (rd_done_o) nrd_done++;
            if (wr_done_o) nwr_done++;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        ref_mem[16'd7000] = wr_data;
        chk("rr_event_count", nev, 5);
        for (int k = 0; k < 5 && k < nev; k++) begin
            chk("rr_ack_cycle", ev_cyc[k], 1 + 4 * k);
            chk("rr_ack_side", ev_wr[k], k % 2);
        end
        chk("rr_rd_dones", nrd_done, 2);
        chk("rr_wr_dones", nwr_done, 2);
        repeat (3) @(negedge clk);
        last_win = ref_win(16'd1000, 16'd30);
        chk("rr_window", rd_window_o, last_win);

        // reset while a read sits in WAIT
        ram_lat = 3;
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 16'd200; rd_off = 16'd10;
        @(negedge clk);
        chk("mid_ack", rd_ack_o, 1);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_in_wait", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_en", ram_en_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_window", rd_window_o, 0);
        last_win = '0;
        nrd_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rd_done_o) nrd_done++;
        end
        chk("mid_no_done", nrd_done, 0);
        do_txn(1'b0, 16'd200, 16'd10, 0);

`ifdef RAM_ACC_TIMEOUT_EN
        // RAM never finishes: timeout ends the read with err, window untouched
        ram_hang = 1'b1;
        do_txn(1'b0, 16'd300, 16'd4, 0);
        ram_hang = 1'b0;
        do_txn(1'b0, 16'd300, 16'd4, 0);
`endif

        // randomized mix over a small address range so writes land inside later windows
        for (int it = 0; it < 30; it++) begin
            op_is_wr = 1'($urandom_range(0, 1));
            r_addr   = ADDR_W'($urandom_range(0, 255));
            r_arg    = op_is_wr ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 12));
            do_txn(op_is_wr, r_addr, r_arg, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Arbitrates the single-port window RAM between two requesters:
  - a window-fetch requester that reads 5x5 shortint windows for the convolution engine;
  - a writeback requester that stores single 16-bit results.
- Drives the RAM enable/write/address/offset/data lines, including the enable drop needed to re-arm the RAM finish flag between transactions.
- Captures the returned window and reports completion to the winning requester.

Parameters:
- ADDR_W, 16, address and row-offset width (shortint).
- DATA_W, 16, data word width (shortint).
- KSIZE, 5, window edge; the window bus is KSIZE*KSIZE*DATA_W bits.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with RAM_ACC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req_i  in  1  window-read request, held until rd_ack_o.
- rd_addr_i  in  ADDR_W  window top-left address.
- rd_offset_i  in  ADDR_W  row pitch.
- rd_ack_o  out  1  one-cycle pulse; read arguments latched.
- rd_done_o  out  1  one-cycle pulse; rd_window_o valid.
- rd_window_o  out  KSIZE*KSIZE*DATA_W  captured window, row 0 col 0 in the LSBs, row-major.
- wr_req_i  in  1  write request, held until wr_ack_o.
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- wr_ack_o  out  1  one-cycle pulse; write arguments latched.
- wr_done_o  out  1  one-cycle pulse; write committed.
- ram_en_o  out  1  RAM enable.
- ram_write_o  out  1  RAM write select.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_offset_o  out  ADDR_W  RAM row offset.
- ram_data_o  out  DATA_W  RAM write data.
- ram_window_i  in  KSIZE*KSIZE*DATA_W  RAM window output, same packing as rd_window_o.
- ram_finish_i  in  1  RAM finish flag; sticky until the next enable rising edge.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  timeout pulse (optional feature).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, last_grant = WR, so the first contended grant goes to RD.
- All outputs are registered.
- FSM: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
- IDLE:
  - With any request pending, arbitrate round-robin:
    - if both requests are high, grant the side not in last_grant;
    - if one is high, grant it.
  - Latch the winner's arguments, pulse its ack, update last_grant, assert ram_en_o, set ram_write_o (1 for WR, 0 for RD), go to ISSUE.
- ISSUE: one cycle. ram_finish_i is ignored here because the stale flag is cleared by the enable edge. Go to WAIT.
- WAIT:
  - Hold ram_en_o and all RAM lines stable.
  - On sampled ram_finish_i=1:
    - RD: register ram_window_i into rd_window_o and pulse rd_done_o.
    - WR: pulse wr_done_o.
    - Both cases: drop ram_en_o, go to RELEASE.
- RELEASE: ram_en_o=0 for exactly one cycle, then IDLE. This guarantees an enable rising edge per transaction.
- Latency and throughput:
  - ack is high in the cycle after the request-sampling edge.
  - done is high 2 cycles after ack, with an ideal RAM.
  - Back-to-back transactions take 4 cycles each.
- rd_window_o holds its value until the next rd_done_o. It is never updated by WR transactions.
- A request arriving during a non-IDLE state waits; no request is lost while held.
- Requesters may change their arguments after ack. Requests deasserted before ack are simply not served.
- RAM lines (address/offset/data) keep their last values in IDLE/RELEASE; ram_en_o=0 gates them.
- Reset mid-operation: ram_en_o falls immediately; the in-flight transaction is abandoned with no done pulse; rd_window_o is cleared.

Optional Feature:
- Macro: RAM_ACC_TIMEOUT_EN.
- Defined:
  - A counter in WAIT increments each cycle.
  - When it reaches TIMEOUT_CYCLES without finish:
    - pulse err_o together with the owner's done pulse;
    - rd_window_o is not updated;
    - go to RELEASE.
  - The counter clears on entering WAIT.
- Undefined: WAIT waits indefinitely, no counter is synthesized, err_o is tied 0.

Test Plan:
1. Reset, then rd_req with addr=100, offset=20; RAM model returns a window -> rd_ack next cycle; rd_done 2 cycles later; rd_window_o equals mem[100+20*r+c]; ram_en_o low for 1 cycle after.
2. Write data=16'h1234 to addr=7, then read addr=7 -> wr_done, then the read window's element [0][0] is 16'h1234; ram_write_o=1 only during the write.
3. rd_req and wr_req asserted together from reset and held -> grants RD, WR, RD, WR alternately, 4 cycles apart.
4. Back-to-back reads at addr 0 and 5 -> ram_en_o shows a 0 cycle between them; the second done is not triggered by the stale finish flag.
5. Assert rst_n=0 during WAIT of a read -> ram_en_o=0 immediately, no rd_done, busy_o=0; after release, a new request completes normally.
6. With RAM_ACC_TIMEOUT_EN and a RAM model that never finishes -> err_o and rd_done pulse after 64 WAIT cycles; the FSM returns to IDLE; rd_window_o is unchanged.
